// File: rtl/clock_monitor_pkg.sv
// rtl/clock_monitor_pkg.sv - shared state encoding and constants for clock_monitor
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } cm_state_t;

  localparam int ERR_W = 8;

endpackage

// File: rtl/clock_monitor_edge_sync.sv
// rtl/clock_monitor_edge_sync.sv - two-flop synchronizer with registered rise/fall edge pulses
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
      rise  <= sync2 & ~prev;
      fall  <= ~sync2 & prev;
    end
  end

endmodule

// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - half-period monitor with lock/loss FSM; CLOCK_MONITOR_ERRCNT_EN enables err_count
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int EXP_HALF = 5000,
  parameter int TOL      = 16,
  parameter int LOCK_N   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [ERR_W-1:0] err_count
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  LO_LIM    = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0]  HI_LIM    = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0]  TMO_CNT   = CNT_W'(EXP_HALF + TOL + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_N);

  cm_state_t         state;
  cm_state_t         state_nxt;
  logic              rise;
  logic              fall;
  logic              edge_seen;
  logic              active;
  logic              measuring;
  logic              in_tol;
  logic              timeout;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_nxt;
  logic              locked_nxt;
  logic              lost_nxt;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_in),
    .rise  (rise),
    .fall  (fall)
  );

  // Outputs below are registered once more so pulses, strobes and state land together.
  assign edge_seen = rise | fall;
  assign active    = (state == MEAS) || (state == LOCKED);
  assign measuring = edge_seen && active;
  assign in_tol    = (cnt >= LO_LIM) && (cnt <= HI_LIM);
  assign timeout   = !edge_seen && active && (cnt == TMO_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // An edge coinciding with the timeout count is simply an out-of-tolerance measurement.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    case (state)
      IDLE: begin
        if (edge_seen) state_nxt = MEAS;
      end
      MEAS: begin
        if (edge_seen) begin
          if (in_tol) begin
            good_nxt = good + GOOD_W'(1);
            if (good_nxt == GOOD_LOCK) state_nxt = LOCKED;
          end else begin
            good_nxt = '0;
          end
        end else if (timeout) begin
          state_nxt = LOST;
        end
      end
      LOCKED: begin
        if (edge_seen) begin
          if (!in_tol) begin
            state_nxt = MEAS;
            good_nxt  = '0;
          end
        end else if (timeout) begin
          state_nxt = LOST;
        end
      end
      LOST: begin
        if (edge_seen) begin
          state_nxt = MEAS;
          good_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    locked_nxt = (state_nxt == LOCKED);
    lost_nxt   = (state_nxt == LOST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period_valid <= 1'b0;
      half_period  <= '0;
      cnt          <= '0;
      good         <= '0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      rise_pulse   <= rise;
      fall_pulse   <= fall;
      period_valid <= measuring;
      good         <= good_nxt;
      locked       <= locked_nxt;
      lost         <= lost_nxt;
      if (measuring) half_period <= cnt;
      if (edge_seen)   cnt <= CNT_W'(1);
      else if (active) cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef CLOCK_MONITOR_ERRCNT_EN
  logic err_inc;

  assign err_inc = (state == LOCKED) && (edge_seen ? !in_tol : timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_count <= '0;
    else if (err_inc && (err_count != '1))   err_count <= err_count + ERR_W'(1);
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// tb/tb_clock_monitor.sv - directed self-checking bench for clock_monitor
module tb_clock_monitor;

  localparam int EH  = 100;
  localparam int TL  = 4;
  localparam int LN  = 4;
  localparam int CW  = 16;
  localparam int TMO = EH + TL + 1;

  logic          clk;
  logic          rst_n;
  logic          clk_in;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] half_period;
  logic          period_valid;
  logic          locked;
  logic          lost;
  logic [7:0]    err_count;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int pv_cnt = 0;
  int last_hp = 0;
  int last_pv_cyc = 0;
  int last_edge_cyc = 0;
  int first_rise_cyc = -1;
  int lock_rise_cyc = -1;
  int lost_rise_cyc = -1;
  int lost_cnt = 0;
  logic prev_locked = 1'b0;
  logic prev_lost = 1'b0;

  int t_tog;
  int pv_snap;
  int lost_snap;

  clock_monitor #(
    .EXP_HALF (EH),
    .TOL      (TL),
    .LOCK_N   (LN),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_in       (clk_in),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (period_valid) begin
      pv_cnt      = pv_cnt + 1;
      last_hp     = int'(half_period);
      last_pv_cyc = cyc;
    end
    if (rise_pulse || fall_pulse) last_edge_cyc = cyc;
    if (rise_pulse && first_rise_cyc < 0) first_rise_cyc = cyc;
    if (locked && !prev_locked) lock_rise_cyc = cyc;
    if (lost && !prev_lost) begin
      lost_rise_cyc = cyc;
      lost_cnt      = lost_cnt + 1;
    end
    prev_locked = locked;
    prev_lost   = lost;
  end

  function automatic int exp_err(input int n);
`ifdef CLOCK_MONITOR_ERRCNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    clk_in = ~clk_in;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_locked"}, int'(locked), 0);
    check_eq({tag, "_lost"}, int'(lost), 0);
    check_eq({tag, "_pv"}, int'(period_valid), 0);
    check_eq({tag, "_hp"}, int'(half_period), 0);
    check_eq({tag, "_err"}, int'(err_count), 0);
    check_eq({tag, "_pulses"}, int'(rise_pulse | fall_pulse), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_cleared("reset");

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Locking from IDLE: first edge only starts the count.
    t_tog = cyc;
    step(100);
    check_eq("edge_latency", first_rise_cyc - t_tog, 4);
    check_eq("idle_no_strobe", pv_cnt, 0);
    step(100);
    step(100);
    step(100);
    check_eq("pre_lock_locked", int'(locked), 0);
    check_eq("pre_lock_pv_cnt", pv_cnt, 3);
    step(96);
    check_eq("lock_locked", int'(locked), 1);
    check_eq("lock_hp", last_hp, 100);
    check_eq("lock_pv_cnt", pv_cnt, 4);
    check_eq("lock_same_cycle", lock_rise_cyc, last_pv_cyc);
    check_eq("lock_lost", int'(lost), 0);

    // Tolerance boundaries.
    step(104);
    check_eq("tol_lo_hp", last_hp, 96);
    check_eq("tol_lo_locked", int'(locked), 1);
    step(95);
    check_eq("tol_hi_hp", last_hp, 104);
    check_eq("tol_hi_locked", int'(locked), 1);
    step(100);
    check_eq("tol_out_hp", last_hp, 95);
    check_eq("tol_out_locked", int'(locked), 0);
    check_eq("tol_out_err", int'(err_count), exp_err(1));
    check_eq("tol_out_lost", int'(lost), 0);
    step(100);
    step(100);
    step(100);
    check_eq("relock_early", int'(locked), 0);
    step(100);
    check_eq("relock_locked", int'(locked), 1);

    // Hold input constant after one more good edge -> timeout.
    step(300);
    check_eq("timeout_lost", int'(lost), 1);
    check_eq("timeout_locked", int'(locked), 0);
    check_eq("timeout_delay", lost_rise_cyc - last_edge_cyc, TMO);
    check_eq("timeout_err", int'(err_count), exp_err(2));
    pv_snap = pv_cnt;
    step(100);
    check_eq("recover_lost", int'(lost), 0);
    check_eq("recover_no_strobe", pv_cnt, pv_snap);
    check_eq("recover_locked", int'(locked), 0);

    // Edge landing exactly on the timeout count.
    step(100);
    step(100);
    step(100);
    step(TMO);
    check_eq("edge_tmo_prelock", int'(locked), 1);
    pv_snap   = pv_cnt;
    lost_snap = lost_cnt;
    step(100);
    check_eq("edge_tmo_hp", last_hp, TMO);
    check_eq("edge_tmo_pv", pv_cnt, pv_snap + 1);
    check_eq("edge_tmo_locked", int'(locked), 0);
    check_eq("edge_tmo_lost", int'(lost), 0);
    check_eq("edge_tmo_no_lost_rise", lost_cnt, lost_snap);
    check_eq("edge_tmo_err", int'(err_count), exp_err(3));

    // Asynchronous reset while locked.
    step(100);
    step(100);
    step(100);
    step(100);
    check_eq("prereset_locked", int'(locked), 1);
    #1;
    rst_n  = 1'b0;
    clk_in = 1'b0;
    #1;
    check_cleared("async_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    pv_snap = pv_cnt;
    step(100);
    check_eq("post_reset_no_strobe", pv_cnt, pv_snap);
    check_eq("post_reset_locked", int'(locked), 0);
    step(100);
    check_eq("post_reset_pv", pv_cnt, pv_snap + 1);
    check_eq("post_reset_hp", last_hp, 100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
